// File: rtl/render_pkg.sv
// Shared types for the triangle setup path: packed vertex layout,
// vertex field offsets and the assembler state encoding.
package render_pkg;

    localparam int VTX_W  = 104;
    localparam int X_LSB  = 88;
    localparam int Y_LSB  = 72;
    localparam int Z_LSB  = 64;
    localparam int U_LSB  = 32;
    localparam int V_LSB  = 0;
    localparam int AREA_W = 35;

    // Field order matches the FIFO word: x is the most significant field.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  z;
        logic [31:0] u;
        logic [31:0] v;
    } vertex_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_CAPTURE,
        S_AREA,
        S_DECIDE,
        S_EMIT
    } asm_state_t;

endpackage

// File: rtl/tri_area_calc.sv
// Registered signed 2x screen-space area of a triangle:
// (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0). 17-bit differences and 34-bit
// products cannot overflow the 35-bit result.
module tri_area_calc
    import render_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  vertex_t                  i_v0,
    input  vertex_t                  i_v1,
    input  vertex_t                  i_v2,
    output logic signed [AREA_W-1:0] o_area
);

    logic signed [16:0]        dx1, dy2, dx2, dy1;
    logic signed [33:0]        prod_a, prod_b;
    logic signed [AREA_W-1:0]  area_d, area_q;

    // Only the screen position takes part in the area.
    logic unused_attr;
    assign unused_attr = ^{i_v0.z, i_v0.u, i_v0.v,
                           i_v1.z, i_v1.u, i_v1.v,
                           i_v2.z, i_v2.u, i_v2.v};

    // Sign-extend each coordinate by one bit before subtracting.
    assign dx1 = $signed({i_v1.x[15], i_v1.x}) - $signed({i_v0.x[15], i_v0.x});
    assign dy2 = $signed({i_v2.y[15], i_v2.y}) - $signed({i_v0.y[15], i_v0.y});
    assign dx2 = $signed({i_v2.x[15], i_v2.x}) - $signed({i_v0.x[15], i_v0.x});
    assign dy1 = $signed({i_v1.y[15], i_v1.y}) - $signed({i_v0.y[15], i_v0.y});

    assign prod_a = dx1 * dy2;
    assign prod_b = dx2 * dy1;
    assign area_d = $signed({prod_a[33], prod_a}) - $signed({prod_b[33], prod_b});

    // Capture the area only when the assembler asks for it, so it stays
    // stable while the triangle waits for the rasterizer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            area_q <= '0;
        end else if (i_en) begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            area_q <= area_d;
        end
    end

    assign o_area = area_q;

endmodule

// File: rtl/triangle_assembler.sv
// Groups three FIFO vertices into a triangle, culls degenerate and
// (optionally) back-facing triangles, and hands survivors to the
// rasterizer over valid/ready. One FIFO pop is in flight at a time.
module triangle_assembler
    import render_pkg::*;
#(
    parameter int VTX_W     = render_pkg::VTX_W,
    parameter int CNT_W     = 16,
    parameter bit CULL_BACK = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cull_en,
    input  logic                     i_fifo_empty,
    input  logic [VTX_W-1:0]         i_fifo_data,
    output logic                     o_fifo_re,
    output logic                     o_tri_valid,
    input  logic                     i_tri_ready,
    output logic [VTX_W-1:0]         o_tri_v0,
    output logic [VTX_W-1:0]         o_tri_v1,
    output logic [VTX_W-1:0]         o_tri_v2,
    output logic signed [AREA_W-1:0] o_tri_area,
    output logic [CNT_W-1:0]         o_tri_count,
    output logic [CNT_W-1:0]         o_cull_count
);

    asm_state_t               state_q, state_d;
    logic [1:0]               idx_q;
    vertex_t                  vtx_q [3];
    logic signed [AREA_W-1:0] area;
    logic                     cull;
    logic                     handshake;
    logic [CNT_W-1:0]         tri_cnt_q, cull_cnt_q;

    tri_area_calc u_area (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (state_q == S_AREA),
        .i_v0    (vtx_q[0]),
        .i_v1    (vtx_q[1]),
        .i_v2    (vtx_q[2]),
        .o_area  (area)
    );

    // Zero area is always dropped; clockwise only when back-face culling is on.
    assign cull      = (area == '0) || (CULL_BACK && i_cull_en && (area < 0));
    assign handshake = o_tri_valid && i_tri_ready;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            S_FETCH:   if (!i_fifo_empty) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (idx_q == 2'd2) ? S_AREA : S_FETCH;
            S_AREA:    state_d = S_DECIDE;
            S_DECIDE:  state_d = cull ? S_FETCH : S_EMIT;
            S_EMIT:    if (i_tri_ready) state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs decoded from state so a reset drops them immediately.
    always_comb begin
        o_fifo_re   = 1'b0;
        o_tri_valid = 1'b0;
        unique case (state_q)
            S_FETCH: o_fifo_re   = !i_fifo_empty;
            S_EMIT:  o_tri_valid = 1'b1;
            default: ;
        endcase
    end

    // Vertex slots and the index of the next slot to fill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q <= 2'd0;
            // NOTE: the vertex slots drive the output ports directly, so
            // they are reset (partial triangles are discarded and outputs read 0).
            for (int i = 0; i < 3; i++) vtx_q[i] <= '0;
        end else begin
            if (state_q == S_CAPTURE) begin
                vtx_q[idx_q] <= vertex_t'(i_fifo_data);
                if (idx_q != 2'd2) idx_q <= idx_q + 2'd1;
            end
            if ((state_q == S_DECIDE && cull) || handshake) idx_q <= 2'd0;
        end
    end

    // Statistics counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tri_cnt_q  <= '0;
            cull_cnt_q <= '0;
        end else begin
            if (handshake)                 tri_cnt_q  <= tri_cnt_q + 1'b1;
            if (state_q == S_DECIDE && cull) cull_cnt_q <= cull_cnt_q + 1'b1;
        end
    end

    assign o_tri_v0     = vtx_q[0];
    assign o_tri_v1     = vtx_q[1];
    assign o_tri_v2     = vtx_q[2];
    assign o_tri_area   = area;
    assign o_tri_count  = tri_cnt_q;
    assign o_cull_count = cull_cnt_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Self-checking bench for triangle_assembler: a queue-based FIFO model
// feeds vertices, a reference model predicts each triangle's area and
// fate, and a monitor scores every handshake against the prediction.
module tb_triangle_assembler;

    typedef struct packed {
        logic [103:0] v0;
        logic [103:0] v1;
        logic [103:0] v2;
        logic [34:0]  area;
    } tri_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cull_en;
    logic         fifo_empty;
    logic [103:0] fifo_data;
    logic         fifo_re;
    logic         tri_valid;
    logic         tri_ready;
    logic [103:0] v0, v1, v2;
    logic [34:0]  area;
    logic [15:0]  tri_count, cull_count;

    triangle_assembler #(.CNT_W(16), .CULL_BACK(1'b1)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cull_en    (cull_en),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_re    (fifo_re),
        .o_tri_valid  (tri_valid),
        .i_tri_ready  (tri_ready),
        .o_tri_v0     (v0),
        .o_tri_v1     (v1),
        .o_tri_v2     (v2),
        .o_tri_area   (area),
        .o_tri_count  (tri_count),
        .o_cull_count (cull_count)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    logic [103:0] fifo_q[$];
    tri_t         exp_q[$];
    int           exp_tri_cnt = 0;
    int           exp_cull_cnt = 0;
    int           pop_cycles[$];
    int           valid_cycles[$];
    logic         re_seen = 1'b0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [103:0] prev_v0, prev_v1, prev_v2;
    logic [34:0]  prev_area;

    task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int get_x(input logic [103:0] v);
        logic signed [15:0] t;
        t = v[103:88];
        return int'(t);
    endfunction

    function automatic int get_y(input logic [103:0] v);
        logic signed [15:0] t;
        t = v[87:72];
        return int'(t);
    endfunction

    function automatic logic [103:0] mk_vtx(input int x, input int y);
        logic [15:0] xs, ys;
        xs = x[15:0];
        ys = y[15:0];
        return {xs, ys, 8'($urandom), $urandom, $urandom};
    endfunction

    function automatic int rnd_coord();
        logic signed [15:0] t;
        if ($urandom % 4 == 0) begin
            t = 16'($urandom);
            return int'(t);
        end
        return int'($urandom_range(200, 0)) - 100;
    endfunction

    // Reference: twice the signed area; zero is dropped, negative is dropped
    // only when back-face culling is on.
    task automatic model_tri(input logic [103:0] a, input logic [103:0] b,
                             input logic [103:0] c, input bit cull);
        longint ar;
        tri_t   t;
        ar = longint'(get_x(b) - get_x(a)) * longint'(get_y(c) - get_y(a))
           - longint'(get_x(c) - get_x(a)) * longint'(get_y(b) - get_y(a));
        if (ar == 0 || (cull && ar < 0)) begin
            exp_cull_cnt++;
        end else begin
            t.v0 = a; t.v1 = b; t.v2 = c; t.area = 35'(ar);
            exp_q.push_back(t);
            exp_tri_cnt++;
        end
    endtask

    task automatic push_vtx(input logic [103:0] v);
        fifo_q.push_back(v);
    endtask

    task automatic push_tri(input logic [103:0] a, input logic [103:0] b,
                            input logic [103:0] c, input bit cull);
        push_vtx(a); push_vtx(b); push_vtx(c);
        model_tri(a, b, c, cull);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit rnd_ready);
        int k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < 800) begin
            step();
            if (rnd_ready) tri_ready = 1'($urandom % 2);
            k++;
        end
        check("drain", 104'(fifo_q.size() + exp_q.size()), 104'(0));
        tri_ready = 1'b1;
        repeat (12) step();
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!tri_valid && k < 40) begin
            step();
            k++;
        end
        check(tag, 104'(tri_valid), 104'(1));
    endtask

    // FIFO model: pops on the edge after a sampled read enable, data
    // becomes valid the next cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re_seen) begin
            check("pop_nonempty", 104'(fifo_q.size() != 0), 104'(1));
            if (fifo_q.size() != 0) begin
                fifo_data <= fifo_q.pop_front();
                pop_cycles.push_back(cyc);
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        re_seen = fifo_re;
        if (tri_valid && !prev_valid) valid_cycles.push_back(cyc);
        if (tri_valid) check("re_low_in_emit", 104'(fifo_re), 104'(0));
        if (tri_valid && prev_valid && !prev_ready) begin
            check("stall_v0", v0, prev_v0);
            check("stall_v1", v1, prev_v1);
            check("stall_v2", v2, prev_v2);
            check("stall_area", 104'(area), 104'(prev_area));
        end
        if (tri_valid && tri_ready) begin
            check("tri_expected", 104'(exp_q.size() != 0), 104'(1));
            if (exp_q.size() != 0) begin
                tri_t t;
                t = exp_q.pop_front();
                check("tri_v0", v0, t.v0);
                check("tri_v1", v1, t.v1);
                check("tri_v2", v2, t.v2);
                check("tri_area", 104'(area), 104'(t.area));
            end
        end
        prev_valid = tri_valid;
        prev_ready = tri_ready;
        prev_v0 = v0; prev_v1 = v1; prev_v2 = v2; prev_area = area;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb, vb;
        logic [103:0] a, b, c;

        rst_n = 1'b0; cull_en = 1'b0; tri_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        repeat (3) step();
        check("rst_re", 104'(fifo_re), 104'(0));
        check("rst_valid", 104'(tri_valid), 104'(0));
        check("rst_v0", v0, 104'(0));
        check("rst_area", 104'(area), 104'(0));
        check("rst_tri_count", 104'(tri_count), 104'(0));
        check("rst_cull_count", 104'(cull_count), 104'(0));
        rst_n = 1'b1;
        repeat (2) step();

        // 1: two CCW triangles back to back, timing and throughput
        cull_en = 1'b1; tri_ready = 1'b1;
        pb = pop_cycles.size(); vb = valid_cycles.size();
        push_tri(mk_vtx(0, 0), mk_vtx(10, 0), mk_vtx(0, 10), 1'b1);
        push_tri(mk_vtx(0, 0), mk_vtx(10, 0), mk_vtx(0, 10), 1'b1);
        wait_idle(1'b0);
        check("t1_events", 104'(pop_cycles.size() >= pb + 6 && valid_cycles.size() >= vb + 2), 104'(1));
        if (pop_cycles.size() >= pb + 6 && valid_cycles.size() >= vb + 2) begin
            check("t1_pop1", 104'(pop_cycles[pb+1] - pop_cycles[pb]), 104'(2));
            check("t1_pop2", 104'(pop_cycles[pb+2] - pop_cycles[pb]), 104'(4));
            check("t1_latency", 104'(valid_cycles[vb] - pop_cycles[pb]), 104'(8));
            check("t1_throughput", 104'(valid_cycles[vb+1] - valid_cycles[vb]), 104'(9));
        end
        check("t1_tri_count", 104'(tri_count), 104'(exp_tri_cnt));

        // 2: CW triangle culled, then emitted with culling off
        vb = valid_cycles.size();
        push_tri(mk_vtx(0, 0), mk_vtx(0, 10), mk_vtx(10, 0), 1'b1);
        wait_idle(1'b0);
        check("t2_no_valid", 104'(valid_cycles.size() - vb), 104'(0));
        check("t2_cull_count", 104'(cull_count), 104'(exp_cull_cnt));
        cull_en = 1'b0;
        push_tri(mk_vtx(0, 0), mk_vtx(0, 10), mk_vtx(10, 0), 1'b0);
        wait_idle(1'b0);
        check("t2_tri_count", 104'(tri_count), 104'(exp_tri_cnt));

        // 3: collinear triangle culled even with culling off
        push_tri(mk_vtx(0, 0), mk_vtx(5, 5), mk_vtx(10, 10), 1'b0);
        wait_idle(1'b0);
        check("t3_cull_count", 104'(cull_count), 104'(exp_cull_cnt));

        // 4: rasterizer stalls for 20 cycles
        cull_en = 1'b1; tri_ready = 1'b0;
        push_tri(mk_vtx(-20, 3), mk_vtx(40, -7), mk_vtx(5, 60), 1'b1);
        wait_valid("t4_valid_seen");
        repeat (20) step();
        check("t4_valid_held", 104'(tri_valid), 104'(1));
        check("t4_re_low", 104'(fifo_re), 104'(0));
        if (exp_q.size() != 0) check("t4_area_held", 104'(area), 104'(exp_q[0].area));
        tri_ready = 1'b1;
        wait_idle(1'b0);
        check("t4_tri_count", 104'(tri_count), 104'(exp_tri_cnt));

        // 5: FIFO runs dry after two vertices
        a = mk_vtx(-100, -100); b = mk_vtx(100, -90); c = mk_vtx(0, 120);
        pb = pop_cycles.size();
        push_vtx(a); push_vtx(b);
        repeat (15) step();
        check("t5_pops", 104'(pop_cycles.size() - pb), 104'(2));
        check("t5_no_valid", 104'(tri_valid), 104'(0));
        push_vtx(c);
        model_tri(a, b, c, 1'b1);
        wait_idle(1'b0);
        check("t5_tri_count", 104'(tri_count), 104'(exp_tri_cnt));

        // 6a: reset while capturing the third vertex
        pb = pop_cycles.size();
        push_vtx(mk_vtx(1, 2)); push_vtx(mk_vtx(30, 4));
        repeat (8) step();
        push_vtx(mk_vtx(3, 50));
        for (int k = 0; k < 20 && pop_cycles.size() < pb + 3; k++) step();
        check("t6_third_pop", 104'(pop_cycles.size() - pb), 104'(3));
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 104'(tri_valid), 104'(0));
        check("t6_rst_re", 104'(fifo_re), 104'(0));
        check("t6_rst_v0", v0, 104'(0));
        check("t6_rst_v1", v1, 104'(0));
        check("t6_rst_tri_count", 104'(tri_count), 104'(0));
        check("t6_rst_cull_count", 104'(cull_count), 104'(0));
        exp_tri_cnt = 0; exp_cull_cnt = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // 6b: reset while a triangle is waiting in emit
        tri_ready = 1'b0;
        push_tri(mk_vtx(0, 0), mk_vtx(8, 1), mk_vtx(2, 9), 1'b1);
        wait_valid("t6_emit_valid");
        rst_n = 1'b0;
        #1;
        check("t6_emit_rst_valid", 104'(tri_valid), 104'(0));
        exp_q.delete();
        exp_tri_cnt = 0; exp_cull_cnt = 0;
        repeat (2) step();
        rst_n = 1'b1;
        tri_ready = 1'b1;
        step();
        push_tri(mk_vtx(-5, -5), mk_vtx(7, -3), mk_vtx(1, 11), 1'b1);
        wait_idle(1'b0);
        check("t6_fresh_tri_count", 104'(tri_count), 104'(1));
        check("t6_fresh_cull_count", 104'(cull_count), 104'(exp_cull_cnt));

        // Random batches, culling on then off, random ready
        for (int bt = 0; bt < 2; bt++) begin
            cull_en = (bt == 0);
            for (int t = 0; t < 12; t++) begin
                a = mk_vtx(rnd_coord(), rnd_coord());
                b = mk_vtx(rnd_coord(), rnd_coord());
                if ($urandom % 5 == 0) c = mk_vtx(get_x(a), get_y(a));
                else                   c = mk_vtx(rnd_coord(), rnd_coord());
                push_tri(a, b, c, cull_en);
            end
            wait_idle(1'b1);
            check("rnd_tri_count", 104'(tri_count), 104'(exp_tri_cnt));
            check("rnd_cull_count", 104'(cull_count), 104'(exp_cull_cnt));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
